data_mem_stage: RTL and testbench



---
 rtl/data_mem_stage_if.sv | 44 ++++
 rtl/data_mem_stage.sv | 106 ++++++++++
 tb/tb_data_mem_stage.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/data_mem_stage_if.sv
// Bundle of lane, main-core write and fetch-handshake signals for data_mem_stage.
// The stage itself connects through the slave modport.
interface data_mem_stage_if #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned TAG_W  = 5
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic                      interlock;
  logic [LANES-1:0]          in_valid;
  logic [LANES-1:0]          in_we;
  logic [LANES*32-1:0]       in_addr;
  logic [LANES*DATA_W-1:0]   in_din;
  logic [LANES*BE_W-1:0]     in_be;
  logic [LANES*TAG_W-1:0]    in_tag;
  logic [LANES-1:0]          ext_we;
  logic [LANES*ADDR_W-1:0]   ext_addr;
  logic [LANES*DATA_W-1:0]   ext_din;
  logic                      fetch_req;
  logic [ADDR_W-1:0]         fetch_addr;
  logic                      fetch_ready;
  logic                      fetch_valid;
  logic [DATA_W-1:0]         fetch_data;
  logic [LANES-1:0]          out_valid;
  logic [LANES*TAG_W-1:0]    out_tag;
  logic [LANES*DATA_W-1:0]   out_dout;
  logic                      err_misaligned;

  modport slave (
    input  interlock, in_valid, in_we, in_addr, in_din, in_be, in_tag,
    input  ext_we, ext_addr, ext_din, fetch_req, fetch_addr,
    output fetch_ready, fetch_valid, fetch_data, out_valid, out_tag, out_dout,
    output err_misaligned
  );

  modport master (
    output interlock, in_valid, in_we, in_addr, in_din, in_be, in_tag,
    output ext_we, ext_addr, ext_din, fetch_req, fetch_addr,
    input  fetch_ready, fetch_valid, fetch_data, out_valid, out_tag, out_dout,
    input  err_misaligned
  );
endinterface

// File: rtl/data_mem_stage.sv
// Data-memory pipeline stage: per-lane registered read/write ports, main-core write ports
// and an interlock-time fetch port onto one shared word-addressed RAM (read-first).
module data_mem_stage #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned TAG_W  = 5
) (
  input logic              clk,
  input logic              rstn,
  data_mem_stage_if.slave  bus
);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [ADDR_W-1:0] w_lane_idx [LANES];
  logic [DATA_W-1:0] w_lane_din [LANES];
  logic [BE_W-1:0]   w_lane_be  [LANES];
  logic [LANES-1:0]  w_lane_mis;
  logic [LANES-1:0]  w_lane_ok;
  logic [LANES-1:0]  w_lane_wr;
  logic [ADDR_W-1:0] w_ext_idx  [LANES];
  logic [DATA_W-1:0] w_ext_din  [LANES];
  logic [LANES-1:0]  w_ext_wr;
  logic              w_unused_addr;

  logic [LANES-1:0]        r_out_valid;
  logic [LANES*TAG_W-1:0]  r_out_tag;
  logic [LANES*DATA_W-1:0] r_out_dout;
  logic                    r_fetch_valid;
  logic [DATA_W-1:0]       r_fetch_data;
  logic                    r_err;

  // Address bits above the word index are intentionally dropped (addresses wrap).
  assign w_unused_addr = ^bus.in_addr;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_lane_idx[i] = bus.in_addr[i*32+2 +: ADDR_W];
      w_lane_din[i] = bus.in_din[i*DATA_W +: DATA_W];
      w_lane_be[i]  = bus.in_be[i*BE_W +: BE_W];
      w_lane_mis[i] = bus.in_valid[i] & (bus.in_addr[i*32 +: 2] != 2'b00);
      w_lane_ok[i]  = bus.in_valid[i] & ~w_lane_mis[i];
      w_lane_wr[i]  = w_lane_ok[i] & bus.in_we[i] & ~bus.interlock & rstn;
      w_ext_idx[i]  = bus.ext_addr[i*ADDR_W +: ADDR_W];
      w_ext_din[i]  = bus.ext_din[i*DATA_W +: DATA_W];
      w_ext_wr[i]   = bus.ext_we[i] & rstn;
    end
  end

  // Later nonblocking assignments win: lanes low-to-high first, then ext ports low-to-high,
  // which yields per-byte priority ext > lane and higher index > lower.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (w_lane_wr[i]) begin
        for (int b = 0; b < BE_W; b++) begin
          if (w_lane_be[i][b]) begin
            r_mem[w_lane_idx[i]][b*8 +: 8] <= w_lane_din[i][b*8 +: 8];
          end
        end
      end
    end
    for (int j = 0; j < LANES; j++) begin
      if (w_ext_wr[j]) begin
        r_mem[w_ext_idx[j]] <= w_ext_din[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_out_valid   <= '0;
      r_out_tag     <= '0;
      r_out_dout    <= '0;
      r_fetch_valid <= 1'b0;
      r_fetch_data  <= '0;
      r_err         <= 1'b0;
    end else if (!bus.interlock) begin
      r_out_valid   <= bus.in_valid;
      r_out_tag     <= bus.in_tag;
      r_fetch_valid <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        r_out_dout[i*DATA_W +: DATA_W] <= w_lane_ok[i] ? r_mem[w_lane_idx[i]] : '0;
      end
      if (|w_lane_mis) begin
        r_err <= 1'b1;
      end
    end else begin
      r_fetch_valid <= bus.fetch_req;
      if (bus.fetch_req) begin
        r_fetch_data <= r_mem[bus.fetch_addr];
      end
    end
  end

  assign bus.fetch_ready    = bus.interlock;
  assign bus.fetch_valid    = r_fetch_valid;
  assign bus.fetch_data     = r_fetch_data;
  assign bus.out_valid      = r_out_valid;
  assign bus.out_tag        = r_out_tag;
  assign bus.out_dout       = r_out_dout;
  assign bus.err_misaligned = r_err;

endmodule

// File: tb/tb_data_mem_stage.sv
// Directed vector bench for data_mem_stage: a table of one-cycle vectors with hand-computed
// results, plus reset and write-drop-under-reset sequences.
module tb_data_mem_stage;
  localparam int unsigned LANES  = 2;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 17;
  localparam int unsigned TAG_W  = 5;
  localparam int NV = 27;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  data_mem_stage_if #(
    .LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W)
  ) bus ();

  data_mem_stage #(
    .LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // il, v, we, a0, d0, be0, a1, d1, be1, xwe, xa0, xd0, xa1, xd1, fr, fa,
  // eov, ed0, ed1, efv, efd, eerr
  typedef struct {
    logic [31:0] il, v, we, a0, d0, be0, a1, d1, be1;
    logic [31:0] xwe, xa0, xd0, xa1, xd1, fr, fa;
    logic [31:0] eov, ed0, ed1, efv, efd, eerr;
  } vec_t;

  vec_t tv [NV];
  int total = 0;
  int bad = 0;
  int cur = -1;
  logic [9:0] exp_tag;
  logic [4:0] tg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (step %0d): got %h expected %h", name, cur, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.interlock  = 1'b0;
    bus.in_valid   = '0;
    bus.in_we      = '0;
    bus.in_addr    = '0;
    bus.in_din     = '0;
    bus.in_be      = '0;
    bus.in_tag     = '0;
    bus.ext_we     = '0;
    bus.ext_addr   = '0;
    bus.ext_din    = '0;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
  endtask

  task automatic check_reset_state();
    chk("rst_out_valid", {30'b0, bus.out_valid}, 32'h0);
    chk("rst_out_dout0", bus.out_dout[31:0], 32'h0);
    chk("rst_out_dout1", bus.out_dout[63:32], 32'h0);
    chk("rst_out_tag", {22'b0, bus.out_tag}, 32'h0);
    chk("rst_fetch_valid", {31'b0, bus.fetch_valid}, 32'h0);
    chk("rst_fetch_data", bus.fetch_data, 32'h0);
    chk("rst_err", {31'b0, bus.err_misaligned}, 32'h0);
  endtask

  initial begin
    tv[0]  = '{0, 0,0, 0,0,0, 0,0,0, 3,'h10,0,'h20,0, 0,0, 0,0,0,0,0,0};
    tv[1]  = '{0, 0,0, 0,0,0, 0,0,0, 3,'h40,7,'h0,0, 0,0, 0,0,0,0,0,0};
    tv[2]  = '{0, 1,1, 'h40,'hDEADBEEF,'hF, 0,0,0, 0,0,0,0,0, 0,0, 1,0,0,0,0,0};
    tv[3]  = '{0, 1,0, 'h40,0,0, 0,0,0, 0,0,0,0,0, 0,0, 1,'hDEADBEEF,0,0,0,0};
    tv[4]  = '{0, 1,1, 'h40,'h0000AA00,'h2, 0,0,0, 0,0,0,0,0, 0,0, 1,'hDEADBEEF,0,0,0,0};
    tv[5]  = '{0, 1,0, 'h40,0,0, 0,0,0, 0,0,0,0,0, 0,0, 1,'hDEADAAEF,0,0,0,0};
    tv[6]  = '{0, 3,3, 'h80,'h11111111,'hF, 'h80,'h22222222,'hF, 0,0,0,0,0, 0,0,
               3,0,0,0,0,0};
    tv[7]  = '{0, 3,0, 'h80,0,0, 'h80,0,0, 0,0,0,0,0, 0,0, 3,'h22222222,'h22222222,0,0,0};
    tv[8]  = '{0, 3,3, 'h80,'h44444444,'hF, 'h80,'h55555555,'hF, 1,'h20,'h33333333,0,0, 0,0,
               3,'h22222222,'h22222222,0,0,0};
    tv[9]  = '{0, 3,0, 'h80,0,0, 'h80,0,0, 0,0,0,0,0, 0,0, 3,'h33333333,'h33333333,0,0,0};
    tv[10] = '{0, 3,0, 'h80,0,0, 'h80,0,0, 3,'h20,'hAAAA0000,'h20,'hBBBB0000, 0,0,
               3,'h33333333,'h33333333,0,0,0};
    tv[11] = '{0, 3,0, 'h80,0,0, 'h80,0,0, 0,0,0,0,0, 0,0, 3,'hBBBB0000,'hBBBB0000,0,0,0};
    tv[12] = '{0, 3,3, 'h80,'h11111111,'hF, 'h80,'h000000CC,'h1, 0,0,0,0,0, 0,0,
               3,'hBBBB0000,'hBBBB0000,0,0,0};
    tv[13] = '{0, 3,0, 'h80,0,0, 'h80,0,0, 0,0,0,0,0, 0,0, 3,'h111111CC,'h111111CC,0,0,0};
    tv[14] = '{0, 3,2, 'h100,0,0, 'h100,5,'hF, 0,0,0,0,0, 0,0, 3,7,7,0,0,0};
    tv[15] = '{0, 1,0, 'h100,0,0, 0,0,0, 0,0,0,0,0, 0,0, 1,5,0,0,0,0};
    tv[16] = '{0, 3,0, 'h100,0,0, 'h80,0,0, 1,'h10,'hCAFE,0,0, 0,0, 3,5,'h111111CC,0,0,0};
    tv[17] = '{1, 1,1, 'h100,'h99,'hF, 0,0,0, 0,0,0,0,0, 1,'h10,
               3,5,'h111111CC,1,'hCAFE,0};
    tv[18] = '{1, 2,2, 0,0,0, 'h80,'h77,'hF, 0,0,0,0,0, 1,'h10,
               3,5,'h111111CC,1,'hCAFE,0};
    tv[19] = '{1, 0,0, 0,0,0, 0,0,0, 1,'h40,'h66,0,0, 1,'h40, 3,5,'h111111CC,1,5,0};
    tv[20] = '{0, 3,0, 'h100,0,0, 'h80,0,0, 0,0,0,0,0, 1,'h10, 3,'h66,'h111111CC,0,5,0};
    tv[21] = '{1, 0,0, 0,0,0, 0,0,0, 0,0,0,0,0, 0,0, 3,'h66,'h111111CC,0,5,0};
    tv[22] = '{0, 1,0, 'h41,0,0, 0,0,0, 0,0,0,0,0, 0,0, 1,0,0,0,5,1};
    tv[23] = '{0, 3,1, 'h42,'h12345678,'hF, 'h40,0,0, 0,0,0,0,0, 0,0, 3,0,'hCAFE,0,5,1};
    tv[24] = '{0, 1,0, 'h40,0,0, 0,0,0, 0,0,0,0,0, 0,0, 1,'hCAFE,0,0,5,1};
    tv[25] = '{0, 1,1, 'h80000,'h0BADF00D,'hF, 0,0,0, 0,0,0,0,0, 0,0, 1,0,0,0,5,1};
    tv[26] = '{0, 2,0, 0,0,0, 0,0,0, 0,0,0,0,0, 0,0, 2,0,'h0BADF00D,0,5,1};

    clear_inputs();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    rstn = 1'b1;
    exp_tag = '0;

    for (int k = 0; k < NV; k++) begin
      cur = k;
      tg = k[4:0];
      bus.interlock  = tv[k].il[0];
      bus.in_valid   = tv[k].v[1:0];
      bus.in_we      = tv[k].we[1:0];
      bus.in_addr    = {tv[k].a1, tv[k].a0};
      bus.in_din     = {tv[k].d1, tv[k].d0};
      bus.in_be      = {tv[k].be1[3:0], tv[k].be0[3:0]};
      bus.in_tag     = {~tg, tg};
      bus.ext_we     = tv[k].xwe[1:0];
      bus.ext_addr   = {tv[k].xa1[16:0], tv[k].xa0[16:0]};
      bus.ext_din    = {tv[k].xd1, tv[k].xd0};
      bus.fetch_req  = tv[k].fr[0];
      bus.fetch_addr = tv[k].fa[16:0];
      if (!tv[k].il[0]) exp_tag = {~tg, tg};
      #1;
      chk("fetch_ready", {31'b0, bus.fetch_ready}, tv[k].il);
      @(posedge clk);
      #1;
      chk("out_valid", {30'b0, bus.out_valid}, tv[k].eov);
      chk("out_dout0", bus.out_dout[31:0], tv[k].ed0);
      chk("out_dout1", bus.out_dout[63:32], tv[k].ed1);
      chk("out_tag", {22'b0, bus.out_tag}, {22'b0, exp_tag});
      chk("fetch_valid", {31'b0, bus.fetch_valid}, tv[k].efv);
      chk("fetch_data", bus.fetch_data, tv[k].efd);
      chk("err_misaligned", {31'b0, bus.err_misaligned}, tv[k].eerr);
    end

    // Writes presented while in reset must not land; word 0 keeps 0x0BADF00D.
    cur = NV;
    clear_inputs();
    rstn = 1'b0;
    bus.ext_we   = 2'b01;
    bus.ext_din  = {32'h0, 32'hFFFFFFFF};
    bus.in_valid = 2'b01;
    bus.in_we    = 2'b01;
    bus.in_din   = {32'h0, 32'h12345678};
    bus.in_be    = 8'h0F;
    @(posedge clk);
    #1;
    check_reset_state();

    cur = NV + 1;
    clear_inputs();
    rstn = 1'b1;
    bus.in_valid = 2'b10;
    @(posedge clk);
    #1;
    chk("post_rst_out_valid", {30'b0, bus.out_valid}, 32'h2);
    chk("post_rst_dout0", bus.out_dout[31:0], 32'h0);
    chk("post_rst_dout1", bus.out_dout[63:32], 32'h0BADF00D);
    chk("post_rst_err", {31'b0, bus.err_misaligned}, 32'h0);

    clear_inputs();
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
